// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply or restoring divide.
// Latency: 34 stall cycles then a 1-cycle result strobe; divide-by-zero/overflow take 1 stall cycle.
// Backpressure: holds the pipeline through StallMDE; FlushE aborts at once with no result strobe.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StartE,
  input  logic [2:0]      MDOpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            StallMDE,
  output logic [XLEN-1:0] MDResultE,
  output logic            MDValidE
);

  md_state_t   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  md_op_t      op_q, op_d;
  logic        neg_q, neg_d;
  // Low half holds the multiplier / dividend (shifting out), high half the running product.
  logic [63:0] acc_q, acc_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] res_q, res_d;

  // Operand decode for a starting operation
  md_op_t      op_in;
  logic        a_signed, b_signed, sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic        is_div, is_rem, neg_in, div_zero, div_ovf;
  logic [31:0] special_res;

  // One iteration of each algorithm
  logic [32:0] mul_sum;
  logic [32:0] div_shift, div_diff;
  logic        div_ge;

  // Final sign fix-up and result selection
  logic [63:0] prod_fix;
  logic [31:0] div_sel, div_fix, fix_res;

  logic        unused_bits;

  // Decode the incoming operation: operand signedness, magnitudes, result sign, special cases.
  always_comb begin
    op_in    = md_op_t'(MDOpE);
    a_signed = op_in inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    b_signed = op_in inside {MD_MULH, MD_DIV, MD_REM};
    sign_a   = a_signed & SrcAE[31];
    sign_b   = b_signed & SrcBE[31];
    mag_a    = sign_a ? (32'd0 - SrcAE) : SrcAE;
    mag_b    = sign_b ? (32'd0 - SrcBE) : SrcBE;
    is_div   = MDOpE[2];
    is_rem   = MDOpE[2] & MDOpE[1];
    // Remainder takes the dividend's sign; quotient and product take the XOR.
    neg_in   = is_rem ? sign_a : (sign_a ^ sign_b);
    div_zero = is_div & (SrcBE == 32'd0);
    div_ovf  = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
               (SrcAE == INT_MIN) && (SrcBE == 32'hFFFF_FFFF);
    if (div_zero) begin
      special_res = is_rem ? SrcAE : DIV0_QUOT;
    end else begin
      special_res = is_rem ? 32'd0 : INT_MIN;
    end
  end

  // Datapath for one multiply or divide step, plus the sign-corrected result.
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    div_shift = {rem_q, acc_q[31]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_diff  = div_shift - {1'b0, opb_q};
    prod_fix  = neg_q ? (64'd0 - acc_q) : acc_q;
    div_sel   = op_q[1] ? rem_q : acc_q[31:0];
    div_fix   = neg_q ? (32'd0 - div_sel) : div_sel;
    if (op_q[2]) begin
      fix_res = div_fix;
    end else if (op_q == MD_MUL) begin
      fix_res = prod_fix[31:0];
    end else begin
      fix_res = prod_fix[63:32];
    end
  end

  // The difference's top bit is zero whenever it is selected (div_ge), so it is never stored.
  assign unused_bits = div_diff[32];

  // Next-state logic: start, iterate, fix up sign, strobe result; flush always returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    opb_d   = opb_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (StartE && !FlushE) begin
          op_d  = op_in;
          neg_d = neg_in;
          cnt_d = 5'd0;
          acc_d = {32'd0, mag_a};
          rem_d = 32'd0;
          opb_d = mag_b;
          if (div_zero || div_ovf) begin
            res_d   = special_res;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (op_q[2]) begin
          rem_d = div_ge ? div_diff[31:0] : div_shift[31:0];
          acc_d = {acc_q[63:32], acc_q[30:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        if (cnt_q == 5'd31) begin
          state_d = FIX;
        end
      end
      FIX: begin
        res_d   = fix_res;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (FlushE) begin
      state_d = IDLE;
    end
  end

  // State, counter and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= MD_MUL;
      neg_q   <= 1'b0;
      acc_q   <= 64'd0;
      rem_q   <= 32'd0;
      opb_q   <= 32'd0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
    end
  end

  assign StallMDE  = StartE & ~FlushE & (state_q != DONE);
  assign MDValidE  = (state_q == DONE) & ~FlushE;
  assign MDResultE = res_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with an arithmetic reference model.
// A compare process checks stall/valid/result every cycle against the expected timeline.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        StartE;
  logic [2:0]  MDOpE;
  logic [31:0] SrcAE, SrcBE;
  logic        FlushE;
  logic        StallMDE;
  logic [31:0] MDResultE;
  logic        MDValidE;

  int checks = 0;
  int errors = 0;

  logic        chk_en    = 1'b0;
  logic        exp_stall = 1'b0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_res   = 32'd0;
  int          stall_seen = 0;
  int          valid_seen = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .StartE    (StartE),
    .MDOpE     (MDOpE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .FlushE    (FlushE),
    .StallMDE  (StallMDE),
    .MDResultE (MDResultE),
    .MDValidE  (MDValidE)
  );

  // Reference result straight from RV32M arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      3'b000: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'b010: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 32'd0) ||
                     (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Per-cycle comparison of DUT outputs against the expected timeline.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (StallMDE) stall_seen++;
      if (MDValidE) valid_seen++;
      if (chk_en) begin
        checks++;
        if (StallMDE !== exp_stall) begin
          errors++;
          $display("FAIL cyc_stall t=%0t got %b expected %b", $time, StallMDE, exp_stall);
        end
        checks++;
        if (MDValidE !== exp_valid) begin
          errors++;
          $display("FAIL cyc_valid t=%0t got %b expected %b", $time, MDValidE, exp_valid);
        end
        if (exp_valid) begin
          checks++;
          if (MDResultE !== exp_res) begin
            errors++;
            $display("FAIL cyc_result t=%0t got %h expected %h", $time, MDResultE, exp_res);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, expv);
    end
  endtask

  task automatic idle_cycles(input int n);
    StartE    = 1'b0;
    FlushE    = 1'b0;
    exp_stall = 1'b0;
    exp_valid = 1'b0;
    chk_en    = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Runs one op from its StartE cycle through the DONE cycle; called #1 after a rising edge.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit);
    logic [31:0] m, got;
    int lat, s0, v0;
    m   = model(op, a, b);
    lat = special(op, a, b) ? 1 : 34;
    check("model_pin", m, lit);
    s0 = stall_seen;
    v0 = valid_seen;
    got = 32'd0;
    StartE = 1'b1;
    FlushE = 1'b0;
    MDOpE  = op;
    SrcAE  = a;
    SrcBE  = b;
    chk_en = 1'b1;
    for (int c = 0; c <= lat; c++) begin
      exp_stall = (c < lat);
      exp_valid = (c == lat);
      exp_res   = m;
      @(negedge clk);
      if (c == lat) got = MDResultE;
      @(posedge clk);
      #1;
    end
    StartE    = 1'b0;
    exp_stall = 1'b0;
    exp_valid = 1'b0;
    check("result", got, lit);
    check("stall_cycles", 32'(stall_seen - s0), 32'(lat));
    check("valid_pulses", 32'(valid_seen - v0), 32'd1);
  endtask

  initial begin : main
    int v0;
    reset  = 1'b1;
    StartE = 1'b0;
    FlushE = 1'b0;
    MDOpE  = 3'b000;
    SrcAE  = 32'd0;
    SrcBE  = 32'd0;
    #12;
    check("reset_stall", {31'd0, StallMDE}, 32'd0);
    check("reset_valid", {31'd0, MDValidE}, 32'd0);
    check("reset_result", MDResultE, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_cycles(2);

    // Multiply variants
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op(3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    run_op(3'b001, 32'h8000_0000, 32'h0000_0003, 32'hFFFF_FFFE);

    // Divide variants, including sign combinations
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op(3'b101, 32'd100, 32'd7, 32'd14);
    run_op(3'b111, 32'd100, 32'd7, 32'd2);
    run_op(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run_op(3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1);

    // Special cases: one stall cycle
    run_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op(3'b110, 32'd5, 32'd0, 32'd5);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    idle_cycles(1);

    // Flush in CALC cycle 10: no result strobe afterwards
    StartE = 1'b1;
    MDOpE  = 3'b000;
    SrcAE  = 32'd9;
    SrcBE  = 32'd9;
    chk_en = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) FlushE = 1'b1;
      exp_stall = (c < 10);
      exp_valid = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    v0 = valid_seen;
    idle_cycles(40);
    check("flush_no_valid", 32'(valid_seen - v0), 32'd0);
    run_op(3'b000, 32'd3, 32'd4, 32'd12);

    // StartE with FlushE in IDLE must not start
    StartE    = 1'b1;
    FlushE    = 1'b1;
    exp_stall = 1'b0;
    exp_valid = 1'b0;
    @(posedge clk);
    #1;
    v0 = valid_seen;
    idle_cycles(40);
    check("flush_start_no_valid", 32'(valid_seen - v0), 32'd0);

    // Reset in the middle of CALC
    StartE = 1'b1;
    MDOpE  = 3'b000;
    SrcAE  = 32'd5;
    SrcBE  = 32'd6;
    for (int c = 0; c < 20; c++) begin
      exp_stall = 1'b1;
      exp_valid = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    chk_en = 1'b0;
    reset  = 1'b1;
    StartE = 1'b0;
    #1;
    check("midreset_stall", {31'd0, StallMDE}, 32'd0);
    check("midreset_valid", {31'd0, MDValidE}, 32'd0);
    check("midreset_result", MDResultE, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_cycles(2);

    // Back-to-back ops
    run_op(3'b000, 32'd1234, 32'd5678, 32'd7006652);
    run_op(3'b101, 32'd1000, 32'd33, 32'd30);
    idle_cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
